// File: rtl/mips32_prog_loader.sv
// Boot-time image loader: parses header/data segments from a valid/ready word stream,
// writes them into core memory and releases the core on an end marker. Optional: CHECKSUM_EN.
module mips32_prog_loader #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic [ADDR_W-1:0] start_pc,
   output logic              done,
   output logic              err,
   output logic [7:0]        seg_count,
   output logic [CNT_W-1:0]  words_loaded,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      HDR  = 3'd0,
      DATA = 3'd1,
`ifdef CHECKSUM_EN
      CSUM = 3'd2,
`endif
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              rdy_q;
   logic [ADDR_W-1:0] base_q;
   logic [15:0]       cnt_q;
   logic [15:0]       idx_q;
   logic              xfer;
   logic [15:0]       hdr_base;
   logic [15:0]       hdr_cnt;
   logic [16:0]       hdr_span;
   logic              hdr_end;
   logic              hdr_bad;
   logic              last_word;
   logic              seg_inc;
`ifdef CHECKSUM_EN
   logic [31:0]       csum_q;
   logic              csum_ok;
`endif

   // Valid/ready: a word moves on a rising clk1 edge where s_valid && s_ready are both
   // high; the source holds s_data stable while s_valid && !s_ready, and may idle anytime.
   assign xfer      = s_valid && s_ready;
   assign hdr_base  = s_data[31:16];
   assign hdr_cnt   = s_data[15:0];
   assign hdr_end   = (hdr_cnt == 16'd0);
   // Span is computed one bit wider so a segment ending exactly at the top is legal.
   assign hdr_span  = {1'b0, hdr_base} + {1'b0, hdr_cnt};
   assign hdr_bad   = ((hdr_base >> ADDR_W) != 16'd0) || (hdr_span > (17'd1 << ADDR_W));
   assign last_word = (idx_q == (cnt_q - 16'd1));
`ifdef CHECKSUM_EN
   assign csum_ok   = (s_data == csum_q);
`endif
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      seg_inc   = 1'b0;
      s_ready   = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      core_hold = 1'b1;
      case (state_q)
         HDR: begin
            s_ready = rdy_q;
            if (xfer) begin
               if (hdr_end)
                  state_d = DONE;
               else if (hdr_bad)
                  state_d = ERR;
               else
                  state_d = DATA;
            end
         end
         DATA: begin
            s_ready = rdy_q;
            if (xfer && last_word) begin
`ifdef CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = HDR;
               seg_inc = 1'b1;
`endif
            end
         end
`ifdef CHECKSUM_EN
         CSUM: begin
            s_ready = rdy_q;
            if (xfer) begin
               state_d = csum_ok ? HDR : ERR;
               seg_inc = csum_ok;
            end
         end
`endif
         DONE: begin
            done      = 1'b1;
            core_hold = 1'b0;
         end
         ERR: begin
            err = 1'b1;
         end
         default: begin
            state_d = ERR;
         end
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q      <= HDR;
         rdy_q        <= 1'b0;
         base_q       <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         start_pc     <= '0;
         seg_count    <= '0;
         words_loaded <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         mem_we  <= 1'b0;
         if (xfer && state_q == HDR) begin
            if (hdr_end) begin
               start_pc <= hdr_base[ADDR_W-1:0];
            end else if (!hdr_bad) begin
               base_q <= hdr_base[ADDR_W-1:0];
               cnt_q  <= hdr_cnt;
               idx_q  <= '0;
            end
         end
         if (xfer && state_q == DATA) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_q + idx_q[ADDR_W-1:0];
            mem_wdata <= s_data;
            idx_q     <= idx_q + 16'd1;
            if (words_loaded != '1)
               words_loaded <= words_loaded + 1'b1;
         end
         if (seg_inc && seg_count != 8'hFF)
            seg_count <= seg_count + 8'd1;
      end
   end

`ifdef CHECKSUM_EN
   // Running segment sum, restarted by every accepted header.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst)
         csum_q <= '0;
      else if (xfer && state_q == HDR)
         csum_q <= '0;
      else if (xfer && state_q == DATA)
         csum_q <= csum_q + s_data;
   end
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed + randomized image loads for mips32_prog_loader, checked against a
// segment-level model (expected write queue and running totals).
module tb_mips32_prog_loader;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = 16;

   logic              clk1 = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [31:0]       s_data = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic [ADDR_W-1:0] start_pc;
   logic              done;
   logic              err;
   logic [7:0]        seg_count;
   logic [CNT_W-1:0]  words_loaded;
   logic [2:0]        dbg_state;

   int total = 0;
   int passed = 0;
   int exp_segs = 0;
   int exp_words = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [31:0] seg_buf[16];

   always #5 clk1 = ~clk1;

   mips32_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk1(clk1), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_hold(core_hold), .start_pc(start_pc), .done(done), .err(err),
      .seg_count(seg_count), .words_loaded(words_loaded), .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Every write strobe must match the head of the expected write queue.
   always @(negedge clk1) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0)
            check("unexpected_write", 64'(mem_we), 64'd0);
         else
            check("write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
      end
   end

   task automatic send(input logic [31:0] w, input int gap);
      int n;
      repeat (gap) @(negedge clk1);
      @(negedge clk1);
      s_valid = 1'b1;
      s_data  = w;
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
         @(negedge clk1);
         n++;
      end
      if (n == 50) begin
         check("ready_timeout", 64'(s_ready), 64'd1);
         s_valid = 1'b0;
      end else begin
         @(posedge clk1);
         #1 s_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk1);
      rst = 1'b1;
      s_valid = 1'b0;
      @(negedge clk1);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_core_hold", 64'(core_hold), 64'd1);
      check("rst_start_pc", 64'(start_pc), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_seg_count", 64'(seg_count), 64'd0);
      check("rst_words_loaded", 64'(words_loaded), 64'd0);
      exp_q.delete();
      exp_segs  = 0;
      exp_words = 0;
      rst = 1'b0;
   endtask

   // Sends header, seg_buf[0..n-1] (and checksum when enabled); gaps drawn from [gmin,gmax].
   task automatic send_seg(input int base, input int n, input int gmin, input int gmax,
                           input logic [31:0] csum_delta);
      logic [31:0] sum;
      sum = '0;
      send({16'(base), 16'(n)}, $urandom_range(gmax, gmin));
      for (int i = 0; i < n; i++) begin
         sum += seg_buf[i];
         exp_q.push_back({ADDR_W'(base + i), seg_buf[i]});
         send(seg_buf[i], $urandom_range(gmax, gmin));
      end
      exp_words += n;
`ifdef CHECKSUM_EN
      send(sum + csum_delta, $urandom_range(gmax, gmin));
      if (csum_delta == 32'd0) exp_segs++;
`else
      if (csum_delta == 32'd0) exp_segs++;
`endif
   endtask

   task automatic finish_image(input int pc, input int gap);
      send({16'(pc), 16'd0}, gap);
      @(negedge clk1);
      check("done", 64'(done), 64'd1);
      check("core_hold", 64'(core_hold), 64'd0);
      check("start_pc", 64'(start_pc), 64'(pc));
      check("err", 64'(err), 64'd0);
      check("s_ready_done", 64'(s_ready), 64'd0);
      check("seg_count", 64'(seg_count), 64'(exp_segs > 255 ? 255 : exp_segs));
      check("words_loaded", 64'(words_loaded), 64'(exp_words));
      check("writes_outstanding", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic expect_err(input string tag);
      repeat (3) @(negedge clk1);
      check({tag, "_err"}, 64'(err), 64'd1);
      check({tag, "_core_hold"}, 64'(core_hold), 64'd1);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      check({tag, "_start_pc"}, 64'(start_pc), 64'd0);
   endtask

   initial begin
      int nseg, n, base;
      do_reset();

      // Program load at mem[0..2], start at 0.
      seg_buf[0] = 32'h2801_0063; seg_buf[1] = 32'h2021_0000; seg_buf[2] = 32'hFC00_0000;
      send_seg(0, 3, 0, 0, 32'd0);
      finish_image(0, 0);

      // Data array at mem[99..103], start at 28; then with 2-cycle gaps everywhere.
      for (int g = 0; g <= 2; g += 2) begin
         do_reset();
         seg_buf[0] = 32'd4; seg_buf[1] = 32'd2; seg_buf[2] = 32'd2;
         seg_buf[3] = 32'd3; seg_buf[4] = 32'd2;
         send_seg(99, 5, g, g, 32'd0);
         finish_image(28, g);
      end

      // Segment ending exactly at the top of memory is legal.
      do_reset();
      seg_buf[0] = 32'hDEAD_BEEF;
      send_seg(1023, 1, 0, 1, 32'd0);
      finish_image(5, 1);

      // Out-of-range headers.
      do_reset();
      send(32'h03FF_0002, 0);
      expect_err("bound_span");
      do_reset();
      send(32'h0400_0001, 1);
      expect_err("bound_base");

      // Reset in the middle of a data segment, then a clean reload.
      do_reset();
      send(32'h0064_0004, 0);
      exp_q.push_back({ADDR_W'(100), 32'h1111_0001});
      send(32'h1111_0001, 0);
      exp_q.push_back({ADDR_W'(101), 32'h1111_0002});
      send(32'h1111_0002, 1);
      repeat (2) @(negedge clk1);
      check("pre_reset_writes", 64'(exp_q.size()), 64'd0);
      do_reset();
      seg_buf[0] = 32'h0A; seg_buf[1] = 32'h0B;
      send_seg(100, 2, 0, 1, 32'd0);
      finish_image(100, 0);

`ifdef CHECKSUM_EN
      do_reset();
      seg_buf[0] = 32'd2; seg_buf[1] = 32'd2; seg_buf[2] = 32'd3; seg_buf[3] = 32'd2;
      send_seg(100, 4, 0, 0, 32'd0);
      @(negedge clk1);
      check("csum_ok_seg_count", 64'(seg_count), 64'd1);
      check("csum_ok_s_ready", 64'(s_ready), 64'd1);
      finish_image(0, 0);
      do_reset();
      send_seg(100, 4, 0, 0, 32'd1);
      repeat (3) @(negedge clk1);
      check("csum_bad_err", 64'(err), 64'd1);
      check("csum_bad_seg_count", 64'(seg_count), 64'd0);
      check("csum_bad_words", 64'(words_loaded), 64'd4);
      check("csum_bad_writes", 64'(exp_q.size()), 64'd0);
`endif

      // Randomized multi-segment images.
      for (int img = 0; img < 8; img++) begin
         do_reset();
         nseg = $urandom_range(3, 1);
         for (int s = 0; s < nseg; s++) begin
            n    = $urandom_range(8, 1);
            base = $urandom_range(1024 - n, 0);
            for (int i = 0; i < n; i++) seg_buf[i] = $urandom;
            send_seg(base, n, 0, 2, 32'd0);
         end
         finish_image($urandom_range(1023, 0), $urandom_range(2, 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
